// File: rtl/display_in_pkg.sv
// Shared definitions for the display link: payload widths, receiver state
// encoding and the BCD nibble check used by every BCD consumer.
package display_pkg;

    localparam int BCD_W   = 16;
    localparam int SEG_W   = 32;
    localparam int FRAME_W = BCD_W + SEG_W;
    localparam int CNT_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        DRAIN,
        ERR
    } state_t;

    function automatic logic nibbleValid(input logic [3:0] nib);
        return (nib <= 4'd9);
    endfunction

endpackage

// File: rtl/display_in_if.sv
// Serial side and decoded side of the display link receiver, bundled so the
// receiver and whatever drives it share one port list.
interface display_if;
    import display_pkg::*;

    logic             enable;
    logic             data_in;
    logic             data_valid;
    logic [BCD_W-1:0] bcd_out;
    logic [SEG_W-1:0] segment_out;
    logic             frame_ready;
    logic             frame_error;
    logic             busy;

    modport master (
        output enable, data_in, data_valid,
        input  bcd_out, segment_out, frame_ready, frame_error, busy
    );

    modport slave (
        input  enable, data_in, data_valid,
        output bcd_out, segment_out, frame_ready, frame_error, busy
    );

endinterface

// File: rtl/display_in_bcd_check.sv
// Combinational BCD sanity check: flags a word in which any nibble is above 9.
module bcd_check
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic             bad_o
);

    always_comb begin
        bad_o = 1'b0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (!nibbleValid(bcd_i[i*4 +: 4])) begin
                bad_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_in.sv
// Display link receiver: deserializes a 48-bit MSB-first frame, validates the
// BCD half and publishes both words with one-cycle ready/error pulses.
module display_in
    import display_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    display_if.slave  link
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    state_t             state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] shift_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [BCD_W-1:0]   bcd_q;
    logic [SEG_W-1:0]   seg_q;
    logic               ready_q;
    logic               error_q;
    logic               busy_q;
    logic               pend_q;
    logic               ovrDone_q;
    logic               bcdBad;

    assign shift_d = {shift_q[FRAME_W-2:0], link.data_in};
    assign cnt_d   = cnt_q + 1'b1;

    bcd_check u_bcd_check (
        .bcd_i (shift_q[FRAME_W-1 -: BCD_W]),
        .bad_o (bcdBad)
    );

    // Pulses clear every cycle; everything else only moves while enable is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            seg_q     <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            ovrDone_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            if (link.enable) begin
                unique case (state_q)
                    IDLE: begin
                        if (link.data_valid) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (link.data_valid) begin
                            shift_q <= shift_d;
                            if (cnt_q == LAST_BIT) begin
                                cnt_q   <= '0;
                                state_q <= CHECK;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end else begin
                            cnt_q   <= '0;
                            error_q <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                    // A bit arriving during CHECK is remembered so DRAIN reports it.
                    CHECK: begin
                        pend_q    <= link.data_valid;
                        ovrDone_q <= 1'b0;
                        if (bcdBad) begin
                            error_q <= 1'b1;
                            state_q <= ERR;
                        end else begin
                            bcd_q   <= shift_q[FRAME_W-1 -: BCD_W];
                            seg_q   <= shift_q[SEG_W-1:0];
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DRAIN;
                        end
                    end
                    ERR: begin
                        shift_q   <= '0;
                        busy_q    <= 1'b0;
                        pend_q    <= 1'b0;
                        ovrDone_q <= 1'b1;
                        state_q   <= link.data_valid ? DRAIN : IDLE;
                    end
                    DRAIN: begin
                        if (!ovrDone_q && (pend_q || link.data_valid)) begin
                            error_q   <= 1'b1;
                            ovrDone_q <= 1'b1;
                        end
                        pend_q <= 1'b0;
                        if (!link.data_valid) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign link.bcd_out     = bcd_q;
    assign link.segment_out = seg_q;
    assign link.frame_ready = ready_q;
    assign link.frame_error = error_q;
    assign link.busy        = busy_q;

endmodule

// File: tb/tb_display_in.sv
// Directed bench for display_in: serializes hand-built frames and checks the
// decoded words, pulse timing and pulse counts against fixed expectations.
module tb_display_in;
    import display_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   readyCnt = 0;
    int   errorCnt = 0;
    int   readyBase;
    int   errorBase;

    always #5 clk = ~clk;

    display_if bus();

    display_in dut (
        .clk   (clk),
        .reset (reset),
        .link  (bus)
    );

    // Pulse counters sample shortly after each rising edge, clear of the driver.
    always begin
        @(posedge clk);
        #2;
        if (bus.frame_ready) readyCnt++;
        if (bus.frame_error) errorCnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        @(negedge clk);
        bus.enable     = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = b;
    endtask

    task automatic applyStimulus(input logic [FRAME_W-1:0] frame, input int first, input int last);
        for (int i = first; i >= last; i--) begin
            driveBit(frame[i]);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.enable     = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = 1'b0;
    endtask

    // Called right after the last bit is driven; expects acceptance two edges later.
    task automatic expectAccept(input string tag, input logic [15:0] bcd, input logic [31:0] seg);
        idleCycle();
        checkOutput({tag, "_ready_early"}, 64'(bus.frame_ready), 64'd0);
        checkOutput({tag, "_busy_check"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 64'(bus.frame_ready), 64'd1);
        checkOutput({tag, "_error"}, 64'(bus.frame_error), 64'd0);
        checkOutput({tag, "_bcd"}, 64'(bus.bcd_out), 64'(bcd));
        checkOutput({tag, "_seg"}, 64'(bus.segment_out), 64'(seg));
        checkOutput({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        idleCycle();
        idleCycle();
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_bcd", 64'(bus.bcd_out), 64'd0);
        checkOutput("rst_seg", 64'(bus.segment_out), 64'd0);
        checkOutput("rst_ready", 64'(bus.frame_ready), 64'd0);
        checkOutput("rst_error", 64'(bus.frame_error), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);

        $display("[TB] good frame 2571/C0F83F0F");
        readyBase = readyCnt;
        errorBase = errorCnt;
        applyStimulus({16'h2571, 32'hC0F83F0F}, 47, 0);
        expectAccept("good1", 16'h2571, 32'hC0F83F0F);
        checkOutput("good1_ready_count", 64'(readyCnt - readyBase), 64'd1);
        checkOutput("good1_error_count", 64'(errorCnt - errorBase), 64'd0);

        $display("[TB] bad BCD frame 2A71");
        errorBase = errorCnt;
        readyBase = readyCnt;
        applyStimulus({16'h2A71, 32'h12345678}, 47, 0);
        idleCycle();
        checkOutput("badbcd_error_early", 64'(bus.frame_error), 64'd0);
        @(negedge clk);
        checkOutput("badbcd_error", 64'(bus.frame_error), 64'd1);
        checkOutput("badbcd_ready", 64'(bus.frame_ready), 64'd0);
        checkOutput("badbcd_busy_err", 64'(bus.busy), 64'd1);
        @(negedge clk);
        checkOutput("badbcd_error_clear", 64'(bus.frame_error), 64'd0);
        checkOutput("badbcd_busy_done", 64'(bus.busy), 64'd0);
        checkOutput("badbcd_bcd_kept", 64'(bus.bcd_out), 64'h2571);
        checkOutput("badbcd_seg_kept", 64'(bus.segment_out), 64'hC0F83F0F);
        checkOutput("badbcd_error_count", 64'(errorCnt - errorBase), 64'd1);
        checkOutput("badbcd_ready_count", 64'(readyCnt - readyBase), 64'd0);

        $display("[TB] short frame of 20 bits");
        errorBase = errorCnt;
        applyStimulus({16'h5555, 32'h5555AAAA}, 47, 28);
        idleCycle();
        checkOutput("short_busy", 64'(bus.busy), 64'd1);
        checkOutput("short_error_early", 64'(bus.frame_error), 64'd0);
        @(negedge clk);
        checkOutput("short_error", 64'(bus.frame_error), 64'd1);
        @(negedge clk);
        checkOutput("short_error_clear", 64'(bus.frame_error), 64'd0);
        checkOutput("short_busy_done", 64'(bus.busy), 64'd0);
        checkOutput("short_bcd_kept", 64'(bus.bcd_out), 64'h2571);
        checkOutput("short_seg_kept", 64'(bus.segment_out), 64'hC0F83F0F);
        checkOutput("short_error_count", 64'(errorCnt - errorBase), 64'd1);
        applyStimulus({16'h1234, 32'hFFFF0000}, 47, 0);
        expectAccept("after_short", 16'h1234, 32'hFFFF0000);

        $display("[TB] overrun with 50 bits");
        errorBase = errorCnt;
        readyBase = readyCnt;
        applyStimulus({16'h0859, 32'h12345678}, 47, 0);
        driveBit(1'b1);
        checkOutput("ovr_ready_early", 64'(bus.frame_ready), 64'd0);
        driveBit(1'b0);
        checkOutput("ovr_ready", 64'(bus.frame_ready), 64'd1);
        checkOutput("ovr_bcd", 64'(bus.bcd_out), 64'h0859);
        idleCycle();
        checkOutput("ovr_error", 64'(bus.frame_error), 64'd1);
        checkOutput("ovr_ready_clear", 64'(bus.frame_ready), 64'd0);
        idleCycle();
        checkOutput("ovr_error_clear", 64'(bus.frame_error), 64'd0);
        idleCycle();
        checkOutput("ovr_bcd_kept", 64'(bus.bcd_out), 64'h0859);
        checkOutput("ovr_seg_kept", 64'(bus.segment_out), 64'h12345678);
        checkOutput("ovr_error_count", 64'(errorCnt - errorBase), 64'd1);
        checkOutput("ovr_ready_count", 64'(readyCnt - readyBase), 64'd1);

        $display("[TB] enable pause mid-frame");
        errorBase = errorCnt;
        applyStimulus({16'h4096, 32'hDEADBEEF}, 47, 28);
        @(negedge clk);
        bus.enable = 1'b0;
        checkOutput("pause_cnt_start", 64'(dut.cnt_q), 64'd20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.data_valid = i[0];
            bus.data_in    = ~i[1];
        end
        checkOutput("pause_cnt_end", 64'(dut.cnt_q), 64'd20);
        checkOutput("pause_busy", 64'(bus.busy), 64'd1);
        applyStimulus({16'h4096, 32'hDEADBEEF}, 27, 0);
        expectAccept("pause", 16'h4096, 32'hDEADBEEF);
        checkOutput("pause_error_count", 64'(errorCnt - errorBase), 64'd0);

        $display("[TB] reset at bit 30");
        errorBase = errorCnt;
        applyStimulus({16'h3333, 32'h0F0F0F0F}, 47, 18);
        @(negedge clk);
        reset          = 1'b0;
        bus.data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_bcd", 64'(bus.bcd_out), 64'd0);
        checkOutput("midrst_cnt", 64'(dut.cnt_q), 64'd0);
        idleCycle();
        idleCycle();
        checkOutput("midrst_error_count", 64'(errorCnt - errorBase), 64'd0);
        applyStimulus({16'h9999, 32'h00000001}, 47, 0);
        expectAccept("after_rst", 16'h9999, 32'h00000001);
        checkOutput("after_rst_error_count", 64'(errorCnt - errorBase), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
